encoder_round_ctrl: RTL and testbench
=====================================

# encoder_round_ctrl

Round sequencer for the encoder permutation datapath. It loads a 64-slice × 25-bit state from an input stream into its own state buffer. It then steps the external step units (theta, rho, pi, chi, iota) over ROUNDS rounds, latching each step's result back into the buffer, and finally streams the 64 result slices out. It sits between the encoder's input/output streams and the combinational/multicycle step datapath, including the rho/pi permuter.

## Interface
- ROUNDS, 24, number of rounds; legal range 1–31.
- NSTEPS, 5, steps per round; step_sel counts 0..NSTEPS-1 (0 theta, 1 rho, 2 pi, 3 chi, 4 iota).
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begin a job; honoured only in IDLE.
- abort  in  1  synchronous abort; return to IDLE from any state.
- in_valid  in  1  input slice valid.
- in_ready  out  1  controller accepts an input slice.
- in_slice  in  25  input slice; bit order matches buffer[k][0:24].
- out_valid  out  1  output slice valid.
- out_ready  in  1  downstream accepts an output slice.
- out_slice  out  25  output slice, buffer[out index].
- state_q  out  1600  full buffer to the datapath; slice k occupies bits [25k+24:25k].
- state_d  in  1600  datapath result, same packing.
- step_sel  out  3  active step.
- round_idx  out  5  active round (for the iota constant).
- step_go  out  1  one-cycle launch pulse for the current step.
- step_done  in  1  datapath result valid on state_d.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the last output slice.

## Operation
- States: IDLE, LOAD, GO, WAIT, UNLOAD.
- IDLE → LOAD on start. Slice counter cnt (6 bits) clears.
- LOAD:
  - Transfer on in_valid & in_ready; buffer[cnt] ← in_slice; cnt increments.
  - On the transfer with cnt = 63, go to GO with step_sel = 0 and round_idx = 0.
- GO:
  - step_go = 1 for exactly this cycle, then go to WAIT.
  - step_done is ignored in GO, so minimum datapath latency is 1 cycle.
- WAIT, on step_done:
  - Whole buffer ← state_d in that cycle.
  - If step_sel < NSTEPS-1: step_sel increments, go to GO.
  - Else if round_idx < ROUNDS-1: step_sel ← 0, round_idx increments, go to GO.
  - Else go to UNLOAD with cnt ← 0.
- UNLOAD:
  - out_slice = buffer[cnt]; transfer on out_valid & out_ready; cnt increments.
  - After the transfer with cnt = 63: done pulses the next cycle, go to IDLE.
- start outside IDLE is ignored.
- step_done outside WAIT is ignored.
- abort has priority over every other event in the same cycle:
  - Next state is IDLE; all outputs return to their reset values except the buffer, which is retained.
  - No done pulse.
- The buffer is written only by LOAD transfers and by WAIT on step_done.

## Timing
- Reset values: state IDLE; in_ready 0, out_valid 0, step_go 0, busy 0, done 0; step_sel 0, round_idx 0, cnt 0; buffer all zeros, so state_q = 0 and out_slice = 0.
- All outputs are registered or decoded from state registers. There are no combinational paths from inputs to outputs.
- in_ready = 1 exactly while in LOAD; out_valid = 1 exactly while in UNLOAD.
- start sampled high in IDLE at edge t: LOAD and in_ready = 1 from t+1.
- Load with in_valid held high: 64 cycles; GO in the cycle after the 64th transfer.
- Each step with datapath latency L (step_done L cycles after step_go): L+1 cycles.
- Full compute phase: ROUNDS·NSTEPS·(L+1) cycles.
- Unload with out_ready held high: 64 cycles; done high in the following cycle, which is also the first IDLE cycle (busy = 0).
- Minimum job with ROUNDS = 24 and L = 1: 1 + 64 + 240 + 64 + 1 cycles, from start to the done cycle.
- Backpressure: out_slice and cnt hold while out_valid & !out_ready. Input stalls (!in_valid) insert idle cycles with no buffer write.
- rst_n assertion mid-job: immediate return to reset values, asynchronous to clk.

## Test plan
- Basic job:
  - Setup: ROUNDS = 2; datapath model with L = 1 returning state_q XOR {1600{1'b1}}; slice k = k.
  - Response: 10 step_go pulses with step_sel 0..4 and round_idx 0,0,0,0,0,1,1,1,1,1.
  - Output slices k unchanged (even number of inversions).
  - done exactly 1 cycle after the 64th output.
- Variable latency: datapath L = 7 on chi only. step_go spacing is 8 cycles around chi and 2 elsewhere; extra step_done pulses in GO/IDLE do not alter the buffer.
- Stream throttling:
  - in_valid toggled 1-0 each cycle gives exactly 64 writes over 127 cycles.
  - out_ready low for 5 cycles at cnt = 10: out_slice holds slice 10, no skips or duplicates.
- start while busy during WAIT and UNLOAD is ignored; no second job and no extra done.
- abort in WAIT at round 1, step 3: IDLE the next cycle; busy, step_go and out_valid are 0; no done. A new start then runs a full correct job.
- rst_n pulsed low mid-LOAD (cnt = 30): all outputs reach reset values without a clock edge. The buffer reads zero, and a following job completes normally.

Source files
------------

// File: rtl/encoder_round_ctrl.sv
// rtl/encoder_round_ctrl.sv - round sequencer for the encoder permutation datapath
//
// Loads 64 x 25-bit slices from the input stream into a local state buffer,
// steps the external step units (theta, rho, pi, chi, iota) over ROUNDS rounds,
// latching each result back into the buffer, then streams the 64 slices out.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start, abort        begin a job (IDLE only), synchronous return to IDLE
//   in_valid/in_ready   input slice handshake, in_slice carries the slice
//   out_valid/out_ready output slice handshake, out_slice = buffer[cnt]
//   state_q, state_d    packed buffer to the datapath / datapath result
//   step_sel, round_idx active step and round
//   step_go, step_done  step launch pulse / result valid on state_d
//   busy, done          job in progress / one-cycle completion pulse

module encoder_round_ctrl #(
  parameter int ROUNDS = 24,
  parameter int NSTEPS = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [24:0]   in_slice,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [24:0]   out_slice,
  output logic [1599:0] state_q,
  input  logic [1599:0] state_d,
  output logic [2:0]    step_sel,
  output logic [4:0]    round_idx,
  output logic          step_go,
  input  logic          step_done,
  output logic          busy,
  output logic          done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_GO,
    S_WAIT,
    S_UNLOAD
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [5:0]  cnt;
  logic [24:0] buffer [64];

  logic in_xfer;
  logic out_xfer;
  logic last_step;
  logic last_round;

  // in_ready / out_valid mirror LOAD / UNLOAD, so these are the stream transfers.
  assign in_xfer    = in_ready & in_valid;
  assign out_xfer   = out_valid & out_ready;
  assign last_step  = (step_sel == 3'(NSTEPS - 1));
  assign last_round = (round_idx == 5'(ROUNDS - 1));

  for (genvar k = 0; k < 64; k++) begin : g_pack
    assign state_q[25*k +: 25] = buffer[k];
  end

  assign out_slice = buffer[cnt];

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = S_LOAD;
      S_LOAD:   if (in_xfer && cnt == 6'd63) state_nxt = S_GO;
      S_GO:     state_nxt = S_WAIT;
      S_WAIT: begin
        if (step_done) begin
          state_nxt = (last_step && last_round) ? S_UNLOAD : S_GO;
        end
      end
      S_UNLOAD: if (out_xfer && cnt == 6'd63) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
    // abort outranks every other event in the same cycle
    if (abort) state_nxt = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      step_sel  <= '0;
      round_idx <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      step_go   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      for (int k = 0; k < 64; k++) buffer[k] <= '0;
    end else begin
      state     <= state_nxt;
      // Handshake/status outputs are registered copies of the next state.
      in_ready  <= (state_nxt == S_LOAD);
      out_valid <= (state_nxt == S_UNLOAD);
      step_go   <= (state_nxt == S_GO);
      busy      <= (state_nxt != S_IDLE);
      done      <= 1'b0;
      if (abort) begin
        // buffer is deliberately kept across an abort
        cnt       <= '0;
        step_sel  <= '0;
        round_idx <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) cnt <= '0;
          end
          S_LOAD: begin
            if (in_xfer) begin
              buffer[cnt] <= in_slice;
              cnt         <= cnt + 6'd1;
              if (cnt == 6'd63) begin
                step_sel  <= '0;
                round_idx <= '0;
              end
            end
          end
          S_WAIT: begin
            if (step_done) begin
              for (int k = 0; k < 64; k++) buffer[k] <= state_d[25*k +: 25];
              if (!last_step) begin
                step_sel <= step_sel + 3'd1;
              end else if (!last_round) begin
                step_sel  <= '0;
                round_idx <= round_idx + 5'd1;
              end else begin
                cnt <= '0;
              end
            end
          end
          S_UNLOAD: begin
            if (out_xfer) begin
              cnt <= cnt + 6'd1;
              if (cnt == 6'd63) done <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_encoder_round_ctrl.sv
// tb/tb_encoder_round_ctrl.sv - directed scoreboard bench for encoder_round_ctrl
module tb_encoder_round_ctrl;

  localparam int ROUNDS_TB = 2;
  localparam bit INV_OUT   = ((ROUNDS_TB * 5) % 2) == 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start, abort, in_valid, out_ready, step_done;
  logic [24:0]   in_slice;
  logic          in_ready, out_valid, step_go, busy, done;
  logic [24:0]   out_slice;
  logic [1599:0] state_q, state_d;
  logic [2:0]    step_sel;
  logic [4:0]    round_idx;

  encoder_round_ctrl #(.ROUNDS(ROUNDS_TB), .NSTEPS(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .in_valid(in_valid), .in_ready(in_ready), .in_slice(in_slice),
    .out_valid(out_valid), .out_ready(out_ready), .out_slice(out_slice),
    .state_q(state_q), .state_d(state_d), .step_sel(step_sel),
    .round_idx(round_idx), .step_go(step_go), .step_done(step_done),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int sel;
    int rnd;
    int gap;
  } go_t;

  int            errors = 0;
  int            checks = 0;
  int            cyc = 0;
  int            done_cnt = 0;
  int            lat_chi = 1;
  bit            spur_en = 1'b0;
  logic [1599:0] exp_buf = '0;
  go_t           exp_go[$];
  logic [24:0]   exp_out[$];

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (done) done_cnt <= done_cnt + 1;

  task automatic chk(input string tag, input logic [1599:0] obs, input logic [1599:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h differing_bits=%0d",
             tag, obs[127:0], exp_v[127:0], $countones(obs ^ exp_v));
    end
  endtask

  // Datapath model: inverts the state; latency 1, or lat_chi on chi.
  initial begin : datapath_model
    int            dp_rem;
    bit            dp_pend;
    int            last_go;
    logic [1599:0] dp_res;
    go_t           e;
    step_done = 1'b0;
    state_d   = '0;
    dp_pend   = 1'b0;
    dp_rem    = 0;
    last_go   = 0;
    dp_res    = '0;
    forever begin
      @(posedge clk); #1;
      step_done = 1'b0;
      if (dp_pend) begin
        dp_rem--;
        if (dp_rem == 0) begin
          step_done = 1'b1;
          state_d   = dp_res;
          dp_pend   = 1'b0;
          exp_buf   = ~exp_buf;
        end
      end
      if (step_go) begin
        if (exp_go.size() == 0) begin
          chk("go_unexpected", step_go, 1'b0);
        end else begin
          e = exp_go.pop_front();
          chk("go_step_sel", step_sel, e.sel);
          chk("go_round_idx", round_idx, e.rnd);
          if (e.gap != 0) chk("go_spacing", cyc - last_go, e.gap);
        end
        chk("go_state_q", state_q, exp_buf);
        last_go = cyc;
        dp_pend = 1'b1;
        dp_rem  = (step_sel == 3'd3) ? lat_chi : 1;
        dp_res  = ~state_q;
        if (spur_en) begin
          step_done = 1'b1;
          state_d   = {50{32'($urandom)}};
        end
      end else if (spur_en && !busy) begin
        step_done = 1'b1;
        state_d   = {50{32'($urandom)}};
      end
    end
  end

  task automatic push_go();
    int  prev;
    go_t e;
    prev = -1;
    for (int r = 0; r < ROUNDS_TB; r++) begin
      for (int s = 0; s < 5; s++) begin
        e.sel = s;
        e.rnd = r;
        e.gap = (prev < 0) ? 0 : ((prev == 3) ? lat_chi + 1 : 2);
        prev  = s;
        exp_go.push_back(e);
      end
    end
  endtask

  task automatic start_job(output int t_start);
    start = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
    t_start = cyc;
    chk("start_in_ready", in_ready, 1'b1);
    chk("start_busy", busy, 1'b1);
  endtask

  task automatic load(input logic [24:0] base, input bit toggle, input int nmax, output int ncyc);
    int          n;
    bit          ph;
    bit          x;
    logic [24:0] v;
    n = 0; ncyc = 0; ph = 1'b1;
    while (n < nmax && ncyc < 1000) begin
      v        = base + 25'(n);
      in_valid = toggle ? ph : 1'b1;
      in_slice = v;
      x        = in_valid && in_ready;
      if (x) begin
        exp_buf[25*n +: 25] = v;
        exp_out.push_back(INV_OUT ? ~v : v);
      end
      @(posedge clk); #1;
      if (x) n++;
      ncyc++;
      ph = !ph;
    end
    in_valid = 1'b0;
    chk("load_count", n, nmax);
  endtask

  task automatic unload(input bit stall, input bit poke, output int t_done);
    int          n, k, stall_left;
    bit          x;
    logic [24:0] e;
    n = 0; k = 0; stall_left = stall ? 5 : 0;
    while (n < 64 && k < 3000) begin
      start     = poke && ((!out_valid && k == 3) || (out_valid && n == 20));
      out_ready = !(out_valid && n == 10 && stall_left > 0);
      if (out_valid) begin
        e = (exp_out.size() > 0) ? exp_out[0] : 'x;
        chk("out_slice", out_slice, e);
      end
      x = out_valid && out_ready;
      if (!out_ready) stall_left--;
      @(posedge clk); #1;
      if (x) begin
        if (exp_out.size() > 0) void'(exp_out.pop_front());
        n++;
      end
      k++;
    end
    start     = 1'b0;
    out_ready = 1'b0;
    chk("unload_count", n, 64);
    chk("done_pulse", done, 1'b1);
    chk("done_busy", busy, 1'b0);
    chk("done_out_valid", out_valid, 1'b0);
    t_done = cyc;
    @(posedge clk); #1;
    chk("done_single", done, 1'b0);
  endtask

  initial begin : main
    int t_start, t_done, ncyc, k;
    bit found;
    start = 0; abort = 0; in_valid = 0; in_slice = '0; out_ready = 0;

    // reset state
    #12;
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_step_go", step_go, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_step_sel", step_sel, 3'd0);
    chk("rst_round_idx", round_idx, 5'd0);
    chk("rst_state_q", state_q, '0);
    chk("rst_out_slice", out_slice, 25'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // job 1: basic, L = 1, slice k = k, minimum job length
    lat_chi = 1;
    push_go();
    start_job(t_start);
    load(25'd0, 1'b0, 64, ncyc);
    chk("load_cycles", ncyc, 64);
    chk("go_after_load", step_go, 1'b1);
    chk("in_ready_after_load", in_ready, 1'b0);
    unload(1'b0, 1'b0, t_done);
    chk("job_cycles", t_done - t_start + 2, 150);
    repeat (2) begin @(posedge clk); #1; end
    chk("done_count_1", done_cnt, 1);

    // job 2: chi L = 7, spurious step_done, throttled streams, ignored starts
    lat_chi = 7;
    spur_en = 1'b1;
    push_go();
    start_job(t_start);
    load(25'h1A5000, 1'b1, 64, ncyc);
    chk("toggle_cycles", ncyc, 127);
    unload(1'b1, 1'b1, t_done);
    repeat (4) begin @(posedge clk); #1; end
    chk("idle_spur_state_q", state_q, exp_buf);
    chk("no_second_job", in_ready, 1'b0);
    chk("idle_busy", busy, 1'b0);
    chk("done_count_2", done_cnt, 2);
    spur_en = 1'b0;
    lat_chi = 1;

    // job 3: abort in WAIT at round 1, step 3
    push_go();
    start_job(t_start);
    load(25'h0ABCDE, 1'b0, 64, ncyc);
    found = 1'b0;
    k = 0;
    while (!found && k < 500) begin
      if (step_go && step_sel == 3'd3 && round_idx == 5'd1) found = 1'b1;
      else begin @(posedge clk); #1; k++; end
    end
    chk("abort_reach", found, 1'b1);
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_busy", busy, 1'b0);
    chk("abort_step_go", step_go, 1'b0);
    chk("abort_out_valid", out_valid, 1'b0);
    chk("abort_step_sel", step_sel, 3'd0);
    chk("abort_round_idx", round_idx, 5'd0);
    exp_go.delete();
    exp_out.delete();
    repeat (3) begin @(posedge clk); #1; end
    chk("abort_no_done", done_cnt, 2);

    // job 4: full job after abort
    push_go();
    start_job(t_start);
    load(25'h155AA1, 1'b0, 64, ncyc);
    unload(1'b0, 1'b0, t_done);
    repeat (2) begin @(posedge clk); #1; end
    chk("done_count_4", done_cnt, 3);

    // job 5: reset mid-LOAD at cnt = 30, then a full job
    start_job(t_start);
    load(25'h0F0F0F, 1'b0, 30, ncyc);
    rst_n = 1'b0;
    #2;
    chk("arst_in_ready", in_ready, 1'b0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_out_valid", out_valid, 1'b0);
    chk("arst_step_sel", step_sel, 3'd0);
    chk("arst_round_idx", round_idx, 5'd0);
    chk("arst_state_q", state_q, '0);
    chk("arst_out_slice", out_slice, 25'd0);
    #1;
    rst_n = 1'b1;
    exp_out.delete();
    @(posedge clk); #1;
    push_go();
    start_job(t_start);
    load(25'h1C3C3C, 1'b0, 64, ncyc);
    unload(1'b0, 1'b0, t_done);
    repeat (2) begin @(posedge clk); #1; end
    chk("done_count_5", done_cnt, 4);
    chk("go_all_seen", exp_go.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #400000;
    $display("FAIL global_timeout: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
